wb_team_interconnect: RTL and testbench

//  Parametrised Wishbone (classic) fabric between the Caravel WB master and NUM_TEAMS team wrappers

---
 rtl/nebula_wb_pkg.sv | 15 +
 rtl/wb_ic_decode.sv | 43 ++++
 rtl/wb_team_interconnect.sv | 193 +++++++++++++++++++
 tb/tb_wb_team_interconnect.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/nebula_wb_pkg.sv
// Shared definitions for the nebula Wishbone team interconnect:
// FSM state encoding, error response words and the status region index.
package nebula_wb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } ic_state_t;

  localparam logic [31:0] ERR_UNMAPPED = 32'hBAD0_ADD0;
  localparam logic [31:0] ERR_TIMEOUT  = 32'hDEAD_BEEF;
  localparam logic [7:0]  STATUS_IDX   = 8'hFF;

endpackage

// File: rtl/wb_ic_decode.sv
// Address decoder for the team interconnect. Takes the upper half of the
// Wishbone address and produces a hit flag plus one-hot region selects.
// With WB_IC_ERR_CNT_EN defined, region STATUS_IDX is decoded as well.
module wb_ic_decode
  import nebula_wb_pkg::*;
#(
  parameter int         NUM_TEAMS = 12,
  parameter logic [7:0] GPIO_IDX  = 8'hF0,
  parameter logic [7:0] LA_IDX    = 8'hF1,
  parameter logic [7:0] BASE_HI   = 8'h30
) (
  input  logic [15:0]          adr_hi,
  output logic                 hit,
  output logic [NUM_TEAMS-1:0] team_sel,
  output logic                 gpio_sel,
`ifdef WB_IC_ERR_CNT_EN
  output logic                 status_sel,
`endif
  output logic                 la_sel
);

  logic       base_ok;
  logic [7:0] idx;

  // Region match: base byte must be right, then the index picks a slave.
  always_comb begin
    idx      = adr_hi[7:0];
    base_ok  = (adr_hi[15:8] == BASE_HI);
    team_sel = '0;
    for (int i = 0; i < NUM_TEAMS; i++) begin
      team_sel[i] = base_ok && (idx == 8'(i + 1));
    end
    gpio_sel = base_ok && (idx == GPIO_IDX);
    la_sel   = base_ok && (idx == LA_IDX);
`ifdef WB_IC_ERR_CNT_EN
    status_sel = base_ok && (idx == STATUS_IDX);
    hit        = (|team_sel) | gpio_sel | la_sel | status_sel;
`else
    hit        = (|team_sel) | gpio_sel | la_sel;
`endif
  end

endmodule

// File: rtl/wb_team_interconnect.sv
// Registered Wishbone classic fabric between the Caravel master and the
// team wrappers plus GPIO/LA control. One transaction at a time:
// IDLE captures the request, BUSY strobes the selected slave with a
// timeout, RESP returns a one-cycle ack. Unmapped and timed-out accesses
// are answered with an error word and a bus_err_o pulse.
// Optional macro WB_IC_ERR_CNT_EN adds an internal status region (idx FF)
// holding a saturating error counter and the last error address.
module wb_team_interconnect
  import nebula_wb_pkg::*;
#(
  parameter int         NUM_TEAMS   = 12,
  parameter logic [7:0] GPIO_IDX    = 8'hF0,
  parameter logic [7:0] LA_IDX      = 8'hF1,
  parameter logic [7:0] BASE_HI     = 8'h30,
  parameter int         TIMEOUT_CYC = 255
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_i,
  input  logic                   wbs_stb_i,
  input  logic                   wbs_cyc_i,
`ifdef WB_IC_ERR_CNT_EN
  input  logic                   wbs_we_i,
`endif
  input  logic [31:0]            wbs_adr_i,
  output logic                   wbs_ack_o,
  output logic [31:0]            wbs_dat_o,
  output logic [31:0]            adr_truncated,
  output logic [NUM_TEAMS-1:0]   designs_stb,
  output logic                   gpio_control_stb,
  output logic                   la_control_stb,
  input  logic [32*NUM_TEAMS-1:0] designs_dat_o,
  input  logic [NUM_TEAMS-1:0]   designs_ack_o,
  input  logic [31:0]            gpio_control_dat_o,
  input  logic                   gpio_control_ack_o,
  input  logic [31:0]            la_control_dat_o,
  input  logic                   la_control_ack_o,
  output logic                   bus_err_o
);

  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYC - 1);

  ic_state_t             state;
  logic [15:0]           adr_q;
  logic [15:0]           timeout_cnt;
  logic                  req;
  logic                  dec_hit;
  logic [NUM_TEAMS-1:0]  dec_team;
  logic                  dec_gpio;
  logic                  dec_la;
  logic                  sel_ack;
  logic [31:0]           sel_dat;
`ifdef WB_IC_ERR_CNT_EN
  logic                  dec_status;
  logic [15:0]           adr_hi_q;
  logic [15:0]           err_cnt;
  logic [31:0]           last_err_adr;
`endif

  assign req           = wbs_stb_i & wbs_cyc_i;
  assign adr_truncated = {16'h0000, adr_q};

  wb_ic_decode #(
    .NUM_TEAMS (NUM_TEAMS),
    .GPIO_IDX  (GPIO_IDX),
    .LA_IDX    (LA_IDX),
    .BASE_HI   (BASE_HI)
  ) u_decode (
    .adr_hi    (wbs_adr_i[31:16]),
    .hit       (dec_hit),
    .team_sel  (dec_team),
    .gpio_sel  (dec_gpio),
`ifdef WB_IC_ERR_CNT_EN
    .status_sel(dec_status),
`endif
    .la_sel    (dec_la)
  );

  // Pick ack/data of the currently strobed slave only; others are ignored.
  always_comb begin
    sel_ack = (gpio_control_stb & gpio_control_ack_o) | (la_control_stb & la_control_ack_o);
    sel_dat = '0;
    if (gpio_control_stb) sel_dat = gpio_control_dat_o;
    if (la_control_stb)   sel_dat = la_control_dat_o;
    for (int i = 0; i < NUM_TEAMS; i++) begin
      if (designs_stb[i]) begin
        sel_ack = sel_ack | designs_ack_o[i];
        sel_dat = designs_dat_o[32*i +: 32];
      end
    end
  end

  // Transaction FSM with registered strobes, ack, data and error pulse.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state            <= IDLE;
      adr_q            <= '0;
      timeout_cnt      <= '0;
      designs_stb      <= '0;
      gpio_control_stb <= 1'b0;
      la_control_stb   <= 1'b0;
      wbs_ack_o        <= 1'b0;
      wbs_dat_o        <= '0;
      bus_err_o        <= 1'b0;
`ifdef WB_IC_ERR_CNT_EN
      adr_hi_q         <= '0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          wbs_ack_o   <= 1'b0;
          wbs_dat_o   <= '0;
          bus_err_o   <= 1'b0;
          timeout_cnt <= '0;
          if (req) begin
            adr_q <= wbs_adr_i[15:0];
`ifdef WB_IC_ERR_CNT_EN
            adr_hi_q <= wbs_adr_i[31:16];
`endif
            if (!dec_hit) begin
              state     <= RESP;
              wbs_ack_o <= 1'b1;
              wbs_dat_o <= ERR_UNMAPPED;
              bus_err_o <= 1'b1;
`ifdef WB_IC_ERR_CNT_EN
            end else if (dec_status) begin
              state     <= RESP;
              wbs_ack_o <= 1'b1;
              if (wbs_we_i)          wbs_dat_o <= '0;
              else if (wbs_adr_i[2]) wbs_dat_o <= last_err_adr;
              else                   wbs_dat_o <= {16'h0000, err_cnt};
`endif
            end else begin
              state            <= BUSY;
              designs_stb      <= dec_team;
              gpio_control_stb <= dec_gpio;
              la_control_stb   <= dec_la;
            end
          end
        end
        BUSY: begin
          if (!req) begin
            state            <= IDLE;
            designs_stb      <= '0;
            gpio_control_stb <= 1'b0;
            la_control_stb   <= 1'b0;
            timeout_cnt      <= '0;
          end else if (sel_ack) begin
            state            <= RESP;
            designs_stb      <= '0;
            gpio_control_stb <= 1'b0;
            la_control_stb   <= 1'b0;
            wbs_ack_o        <= 1'b1;
            wbs_dat_o        <= sel_dat;
          end else if (timeout_cnt == TIMEOUT_LAST) begin
            state            <= RESP;
            designs_stb      <= '0;
            gpio_control_stb <= 1'b0;
            la_control_stb   <= 1'b0;
            wbs_ack_o        <= 1'b1;
            wbs_dat_o        <= ERR_TIMEOUT;
            bus_err_o        <= 1'b1;
          end else begin
            timeout_cnt <= timeout_cnt + 16'd1;
          end
        end
        RESP: begin
          state     <= IDLE;
          wbs_ack_o <= 1'b0;
          wbs_dat_o <= '0;
          bus_err_o <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef WB_IC_ERR_CNT_EN
  // Error bookkeeping: a status write clears, each error pulse counts once.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      err_cnt      <= '0;
      last_err_adr <= '0;
    end else if (state == IDLE && req && dec_status && wbs_we_i) begin
      err_cnt      <= '0;
      last_err_adr <= '0;
    end else if (bus_err_o) begin
      if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
      last_err_adr <= {adr_hi_q, adr_q};
    end
  end
`endif

endmodule

// File: tb/tb_wb_team_interconnect.sv
// Scoreboard testbench for wb_team_interconnect (NUM_TEAMS=12, TIMEOUT_CYC=8).
// Expected response words are queued when a request is issued and popped
// when the master ack appears. Define WB_IC_ERR_CNT_EN for the status tests.
module tb_wb_team_interconnect;

  localparam int NT     = 12;
  localparam int TO     = 8;
  localparam int UNMAP  = -1;
  localparam int GPIO_T = 100;
  localparam int LA_T   = 101;
  localparam int STAT_T = 200;

  logic              clk = 1'b0;
  logic              wb_rst_i;
  logic              wbs_stb_i;
  logic              wbs_cyc_i;
`ifdef WB_IC_ERR_CNT_EN
  logic              wbs_we_i;
`endif
  logic [31:0]       wbs_adr_i;
  logic              wbs_ack_o;
  logic [31:0]       wbs_dat_o;
  logic [31:0]       adr_truncated;
  logic [NT-1:0]     designs_stb;
  logic              gpio_control_stb;
  logic              la_control_stb;
  logic [32*NT-1:0]  designs_dat_o;
  logic [NT-1:0]     designs_ack_o;
  logic [31:0]       gpio_control_dat_o;
  logic              gpio_control_ack_o;
  logic [31:0]       la_control_dat_o;
  logic              la_control_ack_o;
  logic              bus_err_o;

  int          checks   = 0;
  int          failures = 0;
  logic [32:0] exp_q[$];

  always #5 clk = ~clk;

  wb_team_interconnect #(
    .NUM_TEAMS   (NT),
    .TIMEOUT_CYC (TO)
  ) dut (
    .wb_clk_i          (clk),
    .wb_rst_i          (wb_rst_i),
    .wbs_stb_i         (wbs_stb_i),
    .wbs_cyc_i         (wbs_cyc_i),
`ifdef WB_IC_ERR_CNT_EN
    .wbs_we_i          (wbs_we_i),
`endif
    .wbs_adr_i         (wbs_adr_i),
    .wbs_ack_o         (wbs_ack_o),
    .wbs_dat_o         (wbs_dat_o),
    .adr_truncated     (adr_truncated),
    .designs_stb       (designs_stb),
    .gpio_control_stb  (gpio_control_stb),
    .la_control_stb    (la_control_stb),
    .designs_dat_o     (designs_dat_o),
    .designs_ack_o     (designs_ack_o),
    .gpio_control_dat_o(gpio_control_dat_o),
    .gpio_control_ack_o(gpio_control_ack_o),
    .la_control_dat_o  (la_control_dat_o),
    .la_control_ack_o  (la_control_ack_o),
    .bus_err_o         (bus_err_o)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request and follow it to the master ack.
  // target: 1..NT team, GPIO_T, LA_T, STAT_T or UNMAP; ack_after<0 = slave never acks.
  task automatic applyStimulus(input logic [31:0] adr, input int target, input int ack_after,
                               input logic [31:0] rdata, input bit spurious);
    logic [32:0]   exp;
    logic [32:0]   got_exp;
    logic [NT-1:0] exp_team;
    logic          exp_gpio;
    logic          exp_la;
    int            stb_cycles;
    int            ack_cycle;
    bit            got;
    exp_team = '0;
    exp_gpio = 1'b0;
    exp_la   = 1'b0;
    if (target >= 1 && target <= NT) begin
      exp_team = NT'(1) << (target - 1);
      designs_dat_o[32*(target-1) +: 32] = rdata;
    end
    if (target == GPIO_T) begin exp_gpio = 1'b1; gpio_control_dat_o = rdata; end
    if (target == LA_T)   begin exp_la   = 1'b1; la_control_dat_o   = rdata; end
    if (target == UNMAP)       exp = {1'b1, 32'hBAD0_ADD0};
    else if (target == STAT_T) exp = {1'b0, rdata};
    else if (ack_after < 0)    exp = {1'b1, 32'hDEAD_BEEF};
    else                       exp = {1'b0, rdata};
    exp_q.push_back(exp);
    wbs_adr_i  = adr;
    wbs_stb_i  = 1'b1;
    wbs_cyc_i  = 1'b1;
    stb_cycles = 0;
    ack_cycle  = -100;
    got        = 1'b0;
    for (int n = 0; n < 40 && !got; n++) begin
      tick();
      designs_ack_o      = '0;
      gpio_control_ack_o = 1'b0;
      la_control_ack_o   = 1'b0;
      if (n == 0) begin
        checkOutput("stb_team", 32'(designs_stb), 32'(exp_team));
        checkOutput("stb_gpio", 32'(gpio_control_stb), 32'(exp_gpio));
        checkOutput("stb_la", 32'(la_control_stb), 32'(exp_la));
        if (target != UNMAP) checkOutput("adr_trunc", adr_truncated, {16'h0000, adr[15:0]});
      end
      if (designs_stb != '0 || gpio_control_stb || la_control_stb) stb_cycles++;
      if (wbs_ack_o) begin
        got = 1'b1;
        got_exp = exp_q.pop_front();
        checkOutput("ack_dat", wbs_dat_o, got_exp[31:0]);
        checkOutput("bus_err", 32'(bus_err_o), 32'(got_exp[32]));
        if (target == UNMAP || target == STAT_T) checkOutput("imm_ack_lat", 32'(n), 32'd0);
        else if (ack_after >= 0)                 checkOutput("ack_lat", 32'(n - ack_cycle), 32'd1);
        else                                     checkOutput("timeout_stb_cyc", 32'(stb_cycles), 32'(TO));
        wbs_stb_i = 1'b0;
        wbs_cyc_i = 1'b0;
      end else begin
        if (n == ack_after) begin
          ack_cycle = n;
          if (target >= 1 && target <= NT) designs_ack_o[target-1] = 1'b1;
          if (target == GPIO_T) gpio_control_ack_o = 1'b1;
          if (target == LA_T)   la_control_ack_o   = 1'b1;
        end
        if (spurious && n == 0) designs_ack_o = '1;
      end
    end
    if (!got) begin
      checkOutput("ack_wait", 32'd0, 32'd1);
      void'(exp_q.pop_front());
      wbs_stb_i = 1'b0;
      wbs_cyc_i = 1'b0;
    end
    tick();
    checkOutput("ack_pulse", 32'(wbs_ack_o), 32'd0);
    checkOutput("dat_idle", wbs_dat_o, 32'd0);
    checkOutput("err_pulse", 32'(bus_err_o), 32'd0);
  endtask

  // Start a team access, then abort it by dropping stb or by reset.
  task automatic abortTest(input logic [31:0] adr, input int team, input int hold, input bit use_reset);
    int ack_seen;
    wbs_adr_i = adr;
    wbs_stb_i = 1'b1;
    wbs_cyc_i = 1'b1;
    for (int i = 0; i < hold; i++) tick();
    checkOutput("abort_stb_on", 32'(designs_stb), 32'(NT'(1) << (team - 1)));
    if (use_reset) wb_rst_i = 1'b1;
    wbs_stb_i = 1'b0;
    wbs_cyc_i = 1'b0;
    tick();
    wb_rst_i = 1'b0;
    checkOutput("abort_stb_off", 32'(designs_stb), 32'd0);
    ack_seen = 0;
    for (int i = 0; i < 4; i++) begin
      if (wbs_ack_o || bus_err_o) ack_seen++;
      tick();
    end
    checkOutput("abort_no_ack", 32'(ack_seen), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired actual=running required=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [7:0] team;
    wb_rst_i           = 1'b1;
    wbs_stb_i          = 1'b0;
    wbs_cyc_i          = 1'b0;
`ifdef WB_IC_ERR_CNT_EN
    wbs_we_i           = 1'b0;
`endif
    wbs_adr_i          = '0;
    designs_ack_o      = '0;
    gpio_control_ack_o = 1'b0;
    la_control_ack_o   = 1'b0;
    gpio_control_dat_o = 32'h6910_0000;
    la_control_dat_o   = 32'h1A00_0000;
    for (int i = 0; i < NT; i++) designs_dat_o[32*i +: 32] = 32'hA000_0000 | 32'(i);
    repeat (3) tick();
    checkOutput("rst_ack", 32'(wbs_ack_o), 32'd0);
    checkOutput("rst_dat", wbs_dat_o, 32'd0);
    checkOutput("rst_err", 32'(bus_err_o), 32'd0);
    checkOutput("rst_stb", 32'({designs_stb, gpio_control_stb, la_control_stb}), 32'd0);
    checkOutput("rst_adr", adr_truncated, 32'd0);
    wb_rst_i = 1'b0;
    tick();

    applyStimulus(32'h3002_0010, 2, 3, 32'h1234_5678, 1'b0);
    applyStimulus(32'h3001_0000, 1, -1, 32'h0, 1'b0);
    applyStimulus(32'h4000_0000, UNMAP, 0, 32'h0, 1'b0);
    applyStimulus(32'h300D_0004, UNMAP, 0, 32'h0, 1'b0);
    applyStimulus(32'h3000_0008, UNMAP, 0, 32'h0, 1'b0);
`ifndef WB_IC_ERR_CNT_EN
    applyStimulus(32'h30FF_0000, UNMAP, 0, 32'h0, 1'b0);
`endif
    applyStimulus(32'h30F0_0020, GPIO_T, 2, 32'hC0DE_0001, 1'b1);
    applyStimulus(32'h30F1_0030, LA_T, 0, 32'h1A1A_2B2B, 1'b1);
    applyStimulus(32'h300C_FFFC, 12, 0, 32'hCAFE_F00D, 1'b0);
    applyStimulus(32'h3005_0100, 5, TO - 1, 32'h5555_AAAA, 1'b0);
    abortTest(32'h3003_0000, 3, 2, 1'b0);
    abortTest(32'h3004_0000, 4, 3, 1'b1);
    applyStimulus(32'h3006_0040, 6, 1, 32'h0606_0606, 1'b0);
    for (int k = 0; k < 4; k++) begin
      team = 8'($urandom_range(1, NT));
      applyStimulus({8'h30, team, 16'($urandom_range(0, 65535))}, int'(team),
                    int'($urandom_range(0, 5)), $urandom, 1'b0);
    end

`ifdef WB_IC_ERR_CNT_EN
    wbs_we_i = 1'b1;
    applyStimulus(32'h30FF_0000, STAT_T, 0, 32'h0, 1'b0);
    wbs_we_i = 1'b0;
    applyStimulus(32'h4000_0000, UNMAP, 0, 32'h0, 1'b0);
    applyStimulus(32'h300D_0000, UNMAP, 0, 32'h0, 1'b0);
    applyStimulus(32'h3001_0000, 1, -1, 32'h0, 1'b0);
    applyStimulus(32'h30FF_0000, STAT_T, 0, 32'd3, 1'b0);
    applyStimulus(32'h30FF_0004, STAT_T, 0, 32'h3001_0000, 1'b0);
    wbs_we_i = 1'b1;
    applyStimulus(32'h30FF_0000, STAT_T, 0, 32'h0, 1'b0);
    wbs_we_i = 1'b0;
    applyStimulus(32'h30FF_0000, STAT_T, 0, 32'h0, 1'b0);
    applyStimulus(32'h30FF_0004, STAT_T, 0, 32'h0, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
